// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: timer FSM states and
// default bit-timing constants.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      RUN       = 2'd2
   } rx_timer_state_t;

   localparam int USB_CLKS_PER_BIT   = 8;
   localparam int USB_SAMPLE_PHASE   = 3;
   localparam int USB_MAX_QUIET_BITS = 7;

endpackage

// File: rtl/usb_rx_timer_if.sv
// Handshake bundle between the RX control/unstuffer side and the bit timer.
interface usb_rx_timer_if;

   logic       rcving;
   logic       d_edge;
   logic       stuff_bit;
   logic       shift_enable;
   logic       byte_received;
   logic [2:0] bit_count;
   logic       sync_err;

   modport master (
      output rcving, d_edge, stuff_bit,
      input  shift_enable, byte_received, bit_count, sync_err
   );

   modport slave (
      input  rcving, d_edge, stuff_bit,
      output shift_enable, byte_received, bit_count, sync_err
   );

endinterface

// File: rtl/rx_phase_counter.sv
// Modulo-MAX_COUNT counter with synchronous clear and enable. The rollover
// flag marks the cycle in which an enabled count steps from the last value
// back to 0; a clear in that cycle suppresses it.
module rx_phase_counter #(
   parameter int MAX_COUNT = 8,
   parameter int WIDTH     = $clog2(MAX_COUNT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             rollover
);

   localparam logic [WIDTH-1:0] LAST_C = WIDTH'(MAX_COUNT - 1);

   logic [WIDTH-1:0] count_r;

   // Phase register: clear has priority over counting, wraps at LAST_C.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clear) begin
         count_r <= {WIDTH{1'b0}};
      end else if (enable) begin
         if (count_r == LAST_C) begin
            count_r <= {WIDTH{1'b0}};
         end else begin
            count_r <= count_r + WIDTH'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

   assign count    = count_r;
   assign rollover = enable && !clear && (count_r == LAST_C);

endmodule

// File: rtl/usb_rx_timer.sv
// USB receive bit-timing scheduler: resynchronises a per-bit phase on every
// line transition, strobes the shift register mid-bit, skips stuffed bits,
// counts data bits into bytes and flags loss of sync on a quiet line.
module usb_rx_timer
   import usb_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT   = USB_CLKS_PER_BIT,
   parameter int SAMPLE_PHASE   = USB_SAMPLE_PHASE,
   parameter int MAX_QUIET_BITS = USB_MAX_QUIET_BITS
) (
   input  logic           clk,
   input  logic           rst,
   usb_rx_timer_if.slave  rx
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam int QW = $clog2(MAX_QUIET_BITS + 1);

   localparam logic [PW-1:0] SAMPLE_C     = PW'(SAMPLE_PHASE);
   localparam logic [QW-1:0] QUIET_LAST_C = QW'(MAX_QUIET_BITS - 1);

   rx_timer_state_t state_r;
   logic [2:0]      bit_count_r;
   logic [QW-1:0]   quiet_cnt_r;
   logic            byte_received_r;
   logic            sync_err_r;

   logic [PW-1:0]   phase_s;
   logic            wrap_s;
   logic            run_s;
   logic            phase_clear_s;
   logic            shift_en_s;
   logic            count_bit_s;
   logic            sync_loss_s;

   assign run_s = (state_r == RUN);

   // Phase only advances in RUN; any edge, idle state or dropped window
   // pins it to 0 so the first RUN cycle always starts at phase 0.
   assign phase_clear_s = !run_s || !rx.rcving || rx.d_edge;

   rx_phase_counter #(
      .MAX_COUNT (CLKS_PER_BIT),
      .WIDTH     (PW)
   ) u_phase (
      .clk      (clk),
      .rst      (rst),
      .clear    (phase_clear_s),
      .enable   (run_s),
      .count    (phase_s),
      .rollover (wrap_s)
   );

   assign shift_en_s  = run_s && (phase_s == SAMPLE_C);
   assign count_bit_s = shift_en_s && !rx.stuff_bit;
   // The wrap that would bring quiet_cnt to MAX_QUIET_BITS is the loss point.
   assign sync_loss_s = run_s && wrap_s && (quiet_cnt_r == QUIET_LAST_C);

   // Timer FSM with bit/quiet counters and registered event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= IDLE;
         bit_count_r     <= 3'd0;
         quiet_cnt_r     <= {QW{1'b0}};
         byte_received_r <= 1'b0;
         sync_err_r      <= 1'b0;
      end else if (!rx.rcving) begin
         state_r         <= IDLE;
         bit_count_r     <= 3'd0;
         quiet_cnt_r     <= {QW{1'b0}};
         byte_received_r <= 1'b0;
         sync_err_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r         <= WAIT_EDGE;
               bit_count_r     <= 3'd0;
               quiet_cnt_r     <= {QW{1'b0}};
               byte_received_r <= 1'b0;
               sync_err_r      <= 1'b0;
            end
            WAIT_EDGE: begin
               state_r         <= rx.d_edge ? RUN : WAIT_EDGE;
               bit_count_r     <= 3'd0;
               quiet_cnt_r     <= {QW{1'b0}};
               byte_received_r <= 1'b0;
               sync_err_r      <= 1'b0;
            end
            RUN: begin
               if (sync_loss_s) begin
                  state_r         <= WAIT_EDGE;
                  bit_count_r     <= 3'd0;
                  quiet_cnt_r     <= {QW{1'b0}};
                  byte_received_r <= 1'b0;
                  sync_err_r      <= 1'b1;
               end else begin
                  state_r    <= RUN;
                  sync_err_r <= 1'b0;
                  if (count_bit_s) begin
                     bit_count_r     <= bit_count_r + 3'd1;
                     byte_received_r <= (bit_count_r == 3'd7);
                  end else begin
                     bit_count_r     <= bit_count_r;
                     byte_received_r <= 1'b0;
                  end
                  if (rx.d_edge) begin
                     quiet_cnt_r <= {QW{1'b0}};
                  end else if (wrap_s) begin
                     quiet_cnt_r <= quiet_cnt_r + QW'(1);
                  end else begin
                     quiet_cnt_r <= quiet_cnt_r;
                  end
               end
            end
            default: begin
               state_r         <= IDLE;
               bit_count_r     <= 3'd0;
               quiet_cnt_r     <= {QW{1'b0}};
               byte_received_r <= 1'b0;
               sync_err_r      <= 1'b0;
            end
         endcase
      end
   end

   assign rx.shift_enable  = shift_en_s;
   assign rx.byte_received = byte_received_r;
   assign rx.bit_count     = bit_count_r;
   assign rx.sync_err      = sync_err_r;

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer at default parameters. Cycle 0 of each
// scenario is the first cycle after reset is released; inputs set in cycle c
// are sampled at the edge that starts cycle c+1.
module tb_usb_rx_timer;
   import usb_rx_pkg::*;

   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   usb_rx_timer_if rx_if ();

   usb_rx_timer dut (
      .clk (clk),
      .rst (rst),
      .rx  (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      rx_if.rcving    = 1'b0;
      rx_if.d_edge    = 1'b0;
      rx_if.stuff_bit = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;

      // Reset / idle: outputs stay 0 while rcving is low, edges ignored.
      do_reset();
      chk_bit("rst_se", rx_if.shift_enable, 1'b0);
      chk_bit("rst_br", rx_if.byte_received, 1'b0);
      chk_bit("rst_se_err", rx_if.sync_err, 1'b0);
      chk_cnt("rst_bc", rx_if.bit_count, 3'd0);
      for (int c = 0; c < 20; c++) begin
         rx_if.d_edge = (c % 2 == 0);
         tick();
         chk_bit($sformatf("idle_se@%0d", c), rx_if.shift_enable, 1'b0);
         chk_bit($sformatf("idle_br@%0d", c), rx_if.byte_received, 1'b0);
         chk_bit($sformatf("idle_err@%0d", c), rx_if.sync_err, 1'b0);
         chk_cnt($sformatf("idle_bc@%0d", c), rx_if.bit_count, 3'd0);
      end

      // Nominal byte: edges at 10,18,..,74; strobes 14..70; byte at 71.
      do_reset();
      for (int c = 0; c <= 76; c++) begin
         rx_if.rcving = 1'b1;
         rx_if.d_edge = (c >= 10 && c <= 74 && (c - 10) % 8 == 0);
         chk_bit($sformatf("nom_se@%0d", c), rx_if.shift_enable,
                 (c >= 14 && c <= 70 && (c - 14) % 8 == 0));
         chk_bit($sformatf("nom_br@%0d", c), rx_if.byte_received, (c == 71));
         chk_bit($sformatf("nom_err@%0d", c), rx_if.sync_err, 1'b0);
         if (c == 15) chk_cnt("nom_bc@15", rx_if.bit_count, 3'd1);
         if (c == 63) chk_cnt("nom_bc@63", rx_if.bit_count, 3'd7);
         if (c == 71) chk_cnt("nom_bc@71", rx_if.bit_count, 3'd0);
         tick();
      end

      // Resync: edge at 10, early edge at 17 (phase 6) -> strobe at 21, not 22.
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         rx_if.rcving = 1'b1;
         rx_if.d_edge = (c == 10 || c == 17);
         chk_bit($sformatf("rs_se@%0d", c), rx_if.shift_enable, (c == 14 || c == 21));
         if (c == 22) chk_cnt("rs_bc@22", rx_if.bit_count, 3'd2);
         tick();
      end

      // Stuff bit on 4th strobe (cycle 38): count holds, byte after 9th strobe.
      do_reset();
      for (int c = 0; c <= 80; c++) begin
         rx_if.rcving    = 1'b1;
         rx_if.d_edge    = (c >= 10 && c <= 74 && (c - 10) % 8 == 0);
         rx_if.stuff_bit = (c == 38);
         chk_bit($sformatf("st_se@%0d", c), rx_if.shift_enable,
                 (c >= 14 && c <= 78 && (c - 14) % 8 == 0));
         chk_bit($sformatf("st_br@%0d", c), rx_if.byte_received, (c == 79));
         if (c == 38) chk_cnt("st_bc@38", rx_if.bit_count, 3'd3);
         if (c == 39) chk_cnt("st_bc@39", rx_if.bit_count, 3'd3);
         if (c == 47) chk_cnt("st_bc@47", rx_if.bit_count, 3'd4);
         tick();
      end
      rx_if.stuff_bit = 1'b0;

      // Sync loss: single edge at 10 -> sync_err at 67; re-lock on edge at 72.
      do_reset();
      for (int c = 0; c <= 79; c++) begin
         rx_if.rcving = 1'b1;
         rx_if.d_edge = (c == 10 || c == 72);
         chk_bit($sformatf("sl_err@%0d", c), rx_if.sync_err, (c == 67));
         chk_bit($sformatf("sl_se@%0d", c), rx_if.shift_enable,
                 ((c >= 14 && c <= 62 && (c - 14) % 8 == 0) || c == 76));
         chk_bit($sformatf("sl_br@%0d", c), rx_if.byte_received, 1'b0);
         if (c == 63) chk_cnt("sl_bc@63", rx_if.bit_count, 3'd7);
         if (c == 67) chk_cnt("sl_bc@67", rx_if.bit_count, 3'd0);
         if (c == 77) chk_cnt("sl_bc@77", rx_if.bit_count, 3'd1);
         tick();
      end

      // Abort: rcving drops in the cycle of the 8th counted strobe (70).
      do_reset();
      for (int c = 0; c <= 80; c++) begin
         rx_if.rcving = (c <= 69);
         rx_if.d_edge = (c >= 10 && c <= 66 && (c - 10) % 8 == 0);
         chk_bit($sformatf("ab_se@%0d", c), rx_if.shift_enable,
                 (c >= 14 && c <= 70 && (c - 14) % 8 == 0));
         chk_bit($sformatf("ab_br@%0d", c), rx_if.byte_received, 1'b0);
         if (c == 70) chk_cnt("ab_bc@70", rx_if.bit_count, 3'd7);
         if (c == 71) begin
            chk_cnt("ab_bc@71", rx_if.bit_count, 3'd0);
            chk_bit("ab_idle@71", (dut.state_r == IDLE), 1'b1);
         end
         tick();
      end

      // Reset mid-byte at cycle 30: everything 0 afterwards, nothing emitted.
      do_reset();
      for (int c = 0; c <= 50; c++) begin
         rx_if.rcving = 1'b1;
         rx_if.d_edge = (c == 10 || c == 18 || c == 26);
         rst          = (c == 30);
         chk_bit($sformatf("mr_se@%0d", c), rx_if.shift_enable,
                 (c == 14 || c == 22 || c == 30));
         chk_bit($sformatf("mr_br@%0d", c), rx_if.byte_received, 1'b0);
         chk_bit($sformatf("mr_err@%0d", c), rx_if.sync_err, 1'b0);
         if (c == 30) chk_cnt("mr_bc@30", rx_if.bit_count, 3'd2);
         if (c >= 31) chk_cnt($sformatf("mr_bc@%0d", c), rx_if.bit_count, 3'd0);
         tick();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
